// File: rtl/dcache_pkg.sv
// Shared types and address-field width helpers for the direct-mapped write-through dcache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } state_e;

  localparam int OFF_W = 2;

  function automatic int word_w(input int words);
    return $clog2(words);
  endfunction

  function automatic int set_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int width, input int sets, input int words);
    return width - OFF_W - $clog2(sets) - $clog2(words);
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage for the dcache: asynchronous read, single-word synchronous write.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SETS  = 16,
  parameter int WORDS = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [set_w(SETS)-1:0]                 i_set,
  input  logic [word_w(WORDS)-1:0]               i_rd_word,
  output logic                                   o_valid,
  output logic [tag_w(WIDTH, SETS, WORDS)-1:0]   o_tag,
  output logic [WIDTH-1:0]                       o_data,
  input  logic                                   i_data_we,
  input  logic [word_w(WORDS)-1:0]               i_wr_word,
  input  logic [WIDTH-1:0]                       i_wr_data,
  input  logic                                   i_fill_done,
  input  logic [tag_w(WIDTH, SETS, WORDS)-1:0]   i_fill_tag
);

  localparam int TB = tag_w(WIDTH, SETS, WORDS);

  logic [SETS-1:0]  r_valid;
  logic [TB-1:0]    r_tag  [SETS];
  logic [WIDTH-1:0] r_data [SETS][WORDS];

  assign o_valid = r_valid[i_set];
  assign o_tag   = r_tag[i_set];
  assign o_data  = r_data[i_set][i_rd_word];

  // Valid bits: cleared by reset, set once a line has been completely refilled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
    end else if (i_fill_done) begin
      r_valid[i_set] <= 1'b1;
    end
  end

  // Tag and data words need no reset; an invalid line is never observed as a hit
  always_ff @(posedge clk) begin
    if (i_fill_done) begin
      r_tag[i_set] <= i_fill_tag;
    end
    if (i_data_we) begin
      r_data[i_set][i_wr_word] <= i_wr_data;
    end
  end

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with a valid/ready backing port.
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
module dcache
  import dcache_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SETS  = 16,
  parameter int WORDS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_M,
  input  logic             memWrite_M,
  input  logic [WIDTH-1:0] ALUResult_M,
  input  logic [WIDTH-1:0] writeData_M,
  output logic [WIDTH-1:0] readData_M,
  output logic             stall_M,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]      hit_count,
  output logic [31:0]      miss_count
`endif
);

  localparam int WB = word_w(WORDS);
  localparam int SB = set_w(SETS);
  localparam int TB = tag_w(WIDTH, SETS, WORDS);

  logic [WB-1:0]    w_word;
  logic [SB-1:0]    w_set;
  logic [TB-1:0]    w_tag;
  logic             w_unused;
  logic             w_line_valid;
  logic [TB-1:0]    w_line_tag;
  logic             w_hit;
  logic             w_data_we;
  logic [WB-1:0]    w_wr_word;
  logic [WIDTH-1:0] w_wr_data;
  logic             w_fill_done;

  state_e        r_state, w_next;
  logic [WB-1:0] r_cnt, w_cnt_next;

  assign w_word   = ALUResult_M[OFF_W +: WB];
  assign w_set    = ALUResult_M[OFF_W + WB +: SB];
  assign w_tag    = ALUResult_M[WIDTH-1 -: TB];
  assign w_unused = ^ALUResult_M[OFF_W-1:0];
  assign w_hit    = w_line_valid && (w_line_tag == w_tag);

  dcache_array #(.WIDTH(WIDTH), .SETS(SETS), .WORDS(WORDS)) u_array (
    .clk         (clk),
    .rst         (rst),
    .i_set       (w_set),
    .i_rd_word   (w_word),
    .o_valid     (w_line_valid),
    .o_tag       (w_line_tag),
    .o_data      (readData_M),
    .i_data_we   (w_data_we),
    .i_wr_word   (w_wr_word),
    .i_wr_data   (w_wr_data),
    .i_fill_done (w_fill_done),
    .i_fill_tag  (w_tag)
  );

  // State and refill word counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state, stall and array-write decode
  always_comb begin
    w_next      = r_state;
    w_cnt_next  = r_cnt;
    stall_M     = 1'b0;
    w_data_we   = 1'b0;
    w_wr_word   = w_word;
    w_wr_data   = writeData_M;
    w_fill_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_M && memWrite_M) begin
          stall_M = 1'b1;
          w_next  = WRITE;
        end else if (req_M && !w_hit) begin
          stall_M    = 1'b1;
          w_next     = REFILL;
          w_cnt_next = '0;
        end else begin
          stall_M = 1'b0;
        end
      end
      REFILL: begin
        stall_M = 1'b1;
        if (mem_ready) begin
          w_data_we  = 1'b1;
          w_wr_word  = r_cnt;
          w_wr_data  = mem_rdata;
          w_cnt_next = r_cnt + WB'(1);
          if (r_cnt == WB'(WORDS - 1)) begin
            w_fill_done = 1'b1;
            w_next      = IDLE;
          end else begin
            w_next = REFILL;
          end
        end else begin
          w_next = REFILL;
        end
      end
      WRITE: begin
        // The store retires on the ready edge, so stall drops in the same cycle
        if (mem_ready) begin
          stall_M   = 1'b0;
          w_next    = IDLE;
          w_data_we = w_hit;
        end else begin
          stall_M = 1'b1;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Backing-port outputs decoded from the registered state; inputs are held while stalled
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {w_tag, w_set, r_cnt, 2'b00};
      end
      WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {ALUResult_M[WIDTH-1:OFF_W], 2'b00};
        mem_wdata = writeData_M;
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

`ifdef DCACHE_STATS_EN
  logic        w_hit_evt;
  logic        w_miss_evt;
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  // Retired load hits and store hits, and refill starts plus store misses
  always_comb begin
    w_hit_evt  = ((r_state == IDLE) && req_M && !memWrite_M && w_hit) ||
                 ((r_state == WRITE) && mem_ready && w_hit);
    w_miss_evt = ((r_state == IDLE) && req_M && !memWrite_M && !w_hit) ||
                 ((r_state == WRITE) && mem_ready && !w_hit);
  end

  // Saturating statistics counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hit_cnt  <= 32'd0;
      r_miss_cnt <= 32'd0;
    end else begin
      if (w_hit_evt && (r_hit_cnt != 32'hFFFF_FFFF)) begin
        r_hit_cnt <= r_hit_cnt + 32'd1;
      end
      if (w_miss_evt && (r_miss_cnt != 32'hFFFF_FFFF)) begin
        r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;
`endif

endmodule
